slurm16_cpu_hazard_pipe: RTL and testbench
==========================================

// Module: slurm16_cpu_hazard_pipe
// PURPOSE
//  Hazard scoreboard pipeline for the slurm16 core.
//  - Carries each p0 instruction's write-back register and flag-modify bit through slots p1..p3.
//  - Feeds them back to the hazard detector as hazard_reg1..3 / modifies_flags1..3.
//  - Consumes the detector's hazard_1..3, generates stall_p0 and injects bubbles until the producer leaves p3.
// PARAMETERS
//  REGISTER_BITS  4   width of register selects; R0 (all-zero) means "no hazard"
// PORTS
//  CLK              in   1   core clock; single clock domain
//  RST              in   1   synchronous, active-high reset
//  p0_valid         in   1   p0 holds a real instruction
//  hazard_reg0      in   4   p0 write-back register from hazard detector
//  modifies_flags0  in   1   p0 writes flags
//  hazard_1         in   1   p0 depends on p1 producer
//  hazard_2         in   1   p0 depends on p2 producer
//  hazard_3         in   1   p0 depends on p3 producer
//  pipeline_stall   in   1   external freeze (memory/port wait)
//  flush            in   1   branch taken: kill p0 and p1
//  hazard_reg1..3   out  4   per-slot write-back register (three ports)
//  modifies_flags1..3 out 1  per-slot flag-modify bit (three ports)
//  stall_p0         out  1   hold fetch/decode (p0 must not advance)
//  stall_cycles     out  16  [SLURM16_HAZARD_STATS_EN only] saturating stall counter
// BEHAVIOUR
//  - Reset: all slots = R0 / 0; state = RUN; cnt = 0; stall_p0 = 0; stall_cycles = 0.
//  - States: RUN, STALL. 2-bit down-counter cnt.
//  - need = 3 if hazard_1, else 2 if hazard_2, else 1 if hazard_3, else 0. Nearest producer dominates.
//  - stall_p0 = (RUN & p0_valid & need!=0 & ~flush) | STALL.
//    - Combinational in RUN (same-cycle detect).
//    - Registered-state driven in STALL.
//  - Advance (pipeline_stall=0):
//    - p3 <= p2; p2 <= p1.
//    - p1 <= bubble (R0, 0) if stall_p0 | flush | ~p0_valid; else {hazard_reg0, modifies_flags0}.
//  - pipeline_stall=1: all slots, state and cnt hold. stall_p0 keeps its current value.
//  - RUN -> STALL on an advancing cycle with stall_p0 & need>1; cnt <= need-1.
//    - need==1 stays in RUN (one bubble).
//  - STALL, advancing: cnt <= cnt-1. cnt==1 -> RUN next cycle.
//  - Total stall_p0 cycles = need: hazard_1 -> 3, hazard_2 -> 2, hazard_3 -> 1.
//  - Detector inputs are ignored in STALL; the counter alone ends the stall.
//  - flush has priority over everything:
//    - p1 <= bubble.
//    - If advancing: p2/p3 shift as normal.
//    - If pipeline_stall: p2/p3 hold, p1 still cleared.
//    - state <= RUN, cnt <= 0.
//  - RST mid-stall: next cycle RUN, all slots bubble, stall_p0 = 0.
//  - R0 is never a hazard. Bubbles are R0 so they never match.
// CONFIGURATION
//  - SLURM16_HAZARD_STATS_EN defined:
//    - stall_cycles increments on every clock with stall_p0=1 & pipeline_stall=0.
//    - Saturates at 16'hFFFF; cleared by RST.
//  - Not defined: port absent, no counter logic.
// STRUCTURE
//  - State encodings (HZ_RUN, HZ_STALL) and R0 go in slurm16_cpu_defs.v.
//  - The need-decode function goes in cpu_decode_functions.v.
//  - One sub-module: slurm16_cpu_hazard_slot (REGISTER_BITS+1 register with hold / bubble / load).
//    Instantiated three times.
// TESTING
//  1. Reset: RST=1 two cycles -> all hazard_reg* = 0, modifies_flags* = 0, stall_p0 = 0.
//  2. Flow: p0_valid=1, hazard_reg0=5, flags0=1, no hazards -> hazard_reg1/2/3 = 5 on cycles +1/+2/+3, flags follow.
//  3. hazard_1 pulse -> stall_p0 high exactly 3 cycles, then RUN.
//     - hazard_reg1 = 0 on 3 consecutive cycles.
//  4. hazard_2 + hazard_3 together -> 2-cycle stall (hazard_2 dominates).
//  5. hazard_1, then pipeline_stall=1 for 4 cycles during STALL -> slots and cnt frozen.
//     - stall_p0 total = 3 advancing cycles.
//  6. flush during STALL with p1=7 -> next cycle hazard_reg1 = 0, stall_p0 = 0, state RUN.
//     - Plus: with STATS_EN, stall_cycles = 3 after scenario 3.

Source files
------------

// File: rtl/slurm16_cpu_hazard_pipe_pkg.sv
// Shared definitions for the slurm16 hazard scoreboard pipeline:
// scoreboard states, the "no register" select and the stall-length decode.
package slurm16_cpu_hazard_pipe_pkg;

    localparam int REGISTER_BITS_DEFAULT = 4;

    // Register select zero is never a hazard; bubbles carry it.
    localparam logic [REGISTER_BITS_DEFAULT-1:0] R0 = '0;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

    // Number of stall cycles needed before p0 may advance.
    // The nearest producer dominates: p1 needs 3, p2 needs 2, p3 needs 1.
    function automatic logic [1:0] hazard_need(input logic h1, input logic h2, input logic h3);
        logic [1:0] n;
        if (h1)
            n = 2'd3;
        else if (h2)
            n = 2'd2;
        else if (h3)
            n = 2'd1;
        else
            n = 2'd0;
        return n;
    endfunction

endpackage

// File: rtl/slurm16_cpu_hazard_slot.sv
// One scoreboard slot: write-back register select plus flag-modify bit.
// Reset and bubble load the empty (R0, no flags) entry; hold freezes it.
module slurm16_cpu_hazard_slot #(
    parameter int REGISTER_BITS = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     hold,
    input  logic                     bubble,
    input  logic [REGISTER_BITS-1:0] d_reg,
    input  logic                     d_flags,
    output logic [REGISTER_BITS-1:0] q_reg,
    output logic                     q_flags
);

    // Slot register: bubble beats hold so a flush can clear a frozen slot.
    always_ff @(posedge CLK) begin
        if (RST || bubble) begin
            q_reg   <= '0;
            q_flags <= 1'b0;
        end else if (!hold) begin
            q_reg   <= d_reg;
            q_flags <= d_flags;
        end
    end

endmodule

// File: rtl/slurm16_cpu_hazard_pipe.sv
// Hazard scoreboard pipeline for the slurm16 core.
// Carries p0's write-back register and flag bit through p1..p3, and stalls p0
// with bubbles until the producer it depends on has left p3.
// Optional feature: define SLURM16_HAZARD_STATS_EN to add the saturating
// stall_cycles counter port.
module slurm16_cpu_hazard_pipe
    import slurm16_cpu_hazard_pipe_pkg::*;
#(
    parameter int REGISTER_BITS = REGISTER_BITS_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     p0_valid,
    input  logic [REGISTER_BITS-1:0] hazard_reg0,
    input  logic                     modifies_flags0,
    input  logic                     hazard_1,
    input  logic                     hazard_2,
    input  logic                     hazard_3,
    input  logic                     pipeline_stall,
    input  logic                     flush,
    output logic [REGISTER_BITS-1:0] hazard_reg1,
    output logic [REGISTER_BITS-1:0] hazard_reg2,
    output logic [REGISTER_BITS-1:0] hazard_reg3,
    output logic                     modifies_flags1,
    output logic                     modifies_flags2,
    output logic                     modifies_flags3,
    output logic                     stall_p0
`ifdef SLURM16_HAZARD_STATS_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    hz_state_t  state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic [1:0] need;

    // Slot 0 is the incoming p0 entry; slots 1..3 are the registered stages.
    logic [REGISTER_BITS-1:0] slot_reg   [0:3];
    logic                     slot_flags [0:3];

    assign need = hazard_need(hazard_1, hazard_2, hazard_3);

    // Stall request: same-cycle detection in RUN, state-driven in STALL.
    always_comb begin
        stall_p0 = 1'b0;
        if (state_reg == HZ_STALL)
            stall_p0 = 1'b1;
        else if (p0_valid && (need != 2'd0) && !flush)
            stall_p0 = 1'b1;
    end

    // Next-state: flush cancels any stall; otherwise only advancing cycles move the FSM.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (flush) begin
            state_next = HZ_RUN;
            cnt_next   = 2'd0;
        end else if (!pipeline_stall) begin
            case (state_reg)
                HZ_RUN: begin
                    if (stall_p0 && (need > 2'd1)) begin
                        state_next = HZ_STALL;
                        cnt_next   = need - 2'd1;
                    end
                end
                HZ_STALL: begin
                    cnt_next = cnt_reg - 2'd1;
                    if (cnt_reg == 2'd1)
                        state_next = HZ_RUN;
                end
                default: begin
                    state_next = HZ_RUN;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // FSM state and stall countdown registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= HZ_RUN;
            cnt_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign slot_reg[0]   = hazard_reg0;
    assign slot_flags[0] = modifies_flags0;

    genvar gi;
    generate
        for (gi = 1; gi <= 3; gi++) begin : g_slot
            logic bubble;
            if (gi == 1) begin : g_head
                // p1 takes a bubble on flush (even when frozen), or when p0 does not advance.
                assign bubble = flush | (~pipeline_stall & (stall_p0 | ~p0_valid));
            end else begin : g_tail
                assign bubble = 1'b0;
            end

            slurm16_cpu_hazard_slot #(
                .REGISTER_BITS(REGISTER_BITS)
            ) u_slot (
                .CLK    (CLK),
                .RST    (RST),
                .hold   (pipeline_stall),
                .bubble (bubble),
                .d_reg  (slot_reg[gi-1]),
                .d_flags(slot_flags[gi-1]),
                .q_reg  (slot_reg[gi]),
                .q_flags(slot_flags[gi])
            );
        end
    endgenerate

    assign hazard_reg1     = slot_reg[1];
    assign hazard_reg2     = slot_reg[2];
    assign hazard_reg3     = slot_reg[3];
    assign modifies_flags1 = slot_flags[1];
    assign modifies_flags2 = slot_flags[2];
    assign modifies_flags3 = slot_flags[3];

`ifdef SLURM16_HAZARD_STATS_EN
    // Saturating count of cycles in which p0 was actually held back.
    always_ff @(posedge CLK) begin
        if (RST)
            stall_cycles <= 16'd0;
        else if (stall_p0 && !pipeline_stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
    end
`endif

endmodule

// File: tb/tb_slurm16_cpu_hazard_pipe.sv
// Self-checking bench for slurm16_cpu_hazard_pipe: a vector table for the
// flow/stall/flush sequences plus hand-written multi-cycle corner cases.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge (stall_p0 reflects current inputs, slots reflect prior edges).
module tb_slurm16_cpu_hazard_pipe;

    logic       CLK = 1'b0;
    logic       RST;
    logic       p0_valid;
    logic [3:0] hazard_reg0;
    logic       modifies_flags0;
    logic       hazard_1, hazard_2, hazard_3;
    logic       pipeline_stall;
    logic       flush;
    logic [3:0] hazard_reg1, hazard_reg2, hazard_reg3;
    logic       modifies_flags1, modifies_flags2, modifies_flags3;
    logic       stall_p0;
`ifdef SLURM16_HAZARD_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    slurm16_cpu_hazard_pipe #(.REGISTER_BITS(4)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .p0_valid       (p0_valid),
        .hazard_reg0    (hazard_reg0),
        .modifies_flags0(modifies_flags0),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .hazard_3       (hazard_3),
        .pipeline_stall (pipeline_stall),
        .flush          (flush),
        .hazard_reg1    (hazard_reg1),
        .hazard_reg2    (hazard_reg2),
        .hazard_reg3    (hazard_reg3),
        .modifies_flags1(modifies_flags1),
        .modifies_flags2(modifies_flags2),
        .modifies_flags3(modifies_flags3),
        .stall_p0       (stall_p0)
`ifdef SLURM16_HAZARD_STATS_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    typedef struct {
        logic       v;
        logic [3:0] r0;
        logic       f0;
        logic       h1, h2, h3, ps, fl;
        logic       es;
        logic [3:0] e1, e2, e3;
        logic       ef1, ef2, ef3;
    } vec_t;

    vec_t vecs [31];

    function automatic vec_t mk(input logic v, input logic [3:0] r0, input logic f0,
                                input logic h1, input logic h2, input logic h3,
                                input logic ps, input logic fl, input logic es,
                                input logic [3:0] e1, input logic ef1,
                                input logic [3:0] e2, input logic ef2,
                                input logic [3:0] e3, input logic ef3);
        vec_t x;
        x.v = v; x.r0 = r0; x.f0 = f0; x.h1 = h1; x.h2 = h2; x.h3 = h3;
        x.ps = ps; x.fl = fl; x.es = es;
        x.e1 = e1; x.ef1 = ef1; x.e2 = e2; x.ef2 = ef2; x.e3 = e3; x.ef3 = ef3;
        return x;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic es,
                           input logic [3:0] e1, input logic ef1,
                           input logic [3:0] e2, input logic ef2,
                           input logic [3:0] e3, input logic ef3);
        check({tag, " stall_p0"}, {15'd0, stall_p0}, {15'd0, es});
        check({tag, " hazard_reg1"}, {12'd0, hazard_reg1}, {12'd0, e1});
        check({tag, " hazard_reg2"}, {12'd0, hazard_reg2}, {12'd0, e2});
        check({tag, " hazard_reg3"}, {12'd0, hazard_reg3}, {12'd0, e3});
        check({tag, " modifies_flags1"}, {15'd0, modifies_flags1}, {15'd0, ef1});
        check({tag, " modifies_flags2"}, {15'd0, modifies_flags2}, {15'd0, ef2});
        check({tag, " modifies_flags3"}, {15'd0, modifies_flags3}, {15'd0, ef3});
        $display("%s: stall=%0b r1=%0h/%0b r2=%0h/%0b r3=%0h/%0b", tag, stall_p0,
                 hazard_reg1, modifies_flags1, hazard_reg2, modifies_flags2,
                 hazard_reg3, modifies_flags3);
    endtask

    // Drive one cycle's inputs shortly after the rising edge.
    task automatic drive(input logic v, input logic [3:0] r0, input logic f0,
                         input logic h1, input logic h2, input logic h3,
                         input logic ps, input logic fl);
        p0_valid = v; hazard_reg0 = r0; modifies_flags0 = f0;
        hazard_1 = h1; hazard_2 = h2; hazard_3 = h3;
        pipeline_stall = ps; flush = fl;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_stats(input string tag, input logic [15:0] exp);
`ifdef SLURM16_HAZARD_STATS_EN
        check({tag, " stall_cycles"}, stall_cycles, exp);
`else
        if (exp == 16'hFFFF) $display("%s: stats disabled", tag);
`endif
    endtask

    initial begin
        // Flow of three tagged instructions, then drain.
        vecs[0]  = mk(1, 4'h5, 1, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[1]  = mk(1, 4'h6, 0, 0,0,0, 0,0, 0, 4'h5,1, 4'h0,0, 4'h0,0);
        vecs[2]  = mk(0, 4'h9, 1, 0,0,0, 0,0, 0, 4'h6,0, 4'h5,1, 4'h0,0);
        vecs[3]  = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h6,0, 4'h5,1);
        vecs[4]  = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h6,0);
        vecs[5]  = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        // hazard_1 pulse: three stall cycles, p1 bubbles.
        vecs[6]  = mk(1, 4'h3, 1, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[7]  = mk(1, 4'h4, 0, 1,0,0, 0,0, 1, 4'h3,1, 4'h0,0, 4'h0,0);
        vecs[8]  = mk(1, 4'h4, 0, 0,0,0, 0,0, 1, 4'h0,0, 4'h3,1, 4'h0,0);
        vecs[9]  = mk(1, 4'h4, 0, 0,0,0, 0,0, 1, 4'h0,0, 4'h0,0, 4'h3,1);
        vecs[10] = mk(1, 4'h4, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[11] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h4,0, 4'h0,0, 4'h0,0);
        vecs[12] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h4,0, 4'h0,0);
        vecs[13] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h4,0);
        vecs[14] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        // hazard_2 and hazard_3 together: hazard_2 wins, two stall cycles;
        // detector inputs held during STALL are ignored.
        vecs[15] = mk(1, 4'h2, 1, 0,1,1, 0,0, 1, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[16] = mk(1, 4'h2, 1, 0,1,1, 0,0, 1, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[17] = mk(1, 4'h2, 1, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[18] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h2,1, 4'h0,0, 4'h0,0);
        vecs[19] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h2,1, 4'h0,0);
        vecs[20] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h2,1);
        vecs[21] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        // hazard_3 alone: single bubble, stays in RUN.
        vecs[22] = mk(1, 4'h8, 0, 0,0,1, 0,0, 1, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[23] = mk(1, 4'h8, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);
        vecs[24] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h8,0, 4'h0,0, 4'h0,0);
        // flush in RUN masks a same-cycle hazard and kills p0.
        vecs[25] = mk(1, 4'h1, 1, 1,0,0, 0,1, 0, 4'h0,0, 4'h8,0, 4'h0,0);
        vecs[26] = mk(1, 4'h1, 1, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h8,0);
        vecs[27] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h1,1, 4'h0,0, 4'h0,0);
        vecs[28] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h1,1, 4'h0,0);
        vecs[29] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h1,1);
        vecs[30] = mk(0, 4'h0, 0, 0,0,0, 0,0, 0, 4'h0,0, 4'h0,0, 4'h0,0);

        // Reset for two cycles with busy inputs.
        RST = 1'b1;
        drive(1, 4'hA, 1, 1, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk_all("reset", 0, 4'h0,0, 4'h0,0, 4'h0,0);
        check_stats("reset", 16'd0);
        RST = 1'b0;
        next_cycle();

        for (int i = 0; i < 31; i++) begin
            drive(vecs[i].v, vecs[i].r0, vecs[i].f0, vecs[i].h1, vecs[i].h2,
                  vecs[i].h3, vecs[i].ps, vecs[i].fl);
            @(negedge CLK);
            chk_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].e1, vecs[i].ef1,
                    vecs[i].e2, vecs[i].ef2, vecs[i].e3, vecs[i].ef3);
            if (i == 10) check_stats("after hazard_1", 16'd3);
            next_cycle();
        end
        check_stats("after table", 16'd6);

        // hazard_1 stall frozen by pipeline_stall for four cycles.
        drive(1, 4'h7, 1, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("frz0", 0, 4'h0,0, 4'h0,0, 4'h0,0);
        next_cycle();
        drive(1, 4'h3, 0, 1, 0, 0, 0, 0);
        @(negedge CLK); chk_all("frz1", 1, 4'h7,1, 4'h0,0, 4'h0,0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'h3, 0, 0, 0, 0, 1, 0);
            @(negedge CLK); chk_all($sformatf("frz_hold%0d", k), 1, 4'h0,0, 4'h7,1, 4'h0,0);
            next_cycle();
        end
        drive(1, 4'h3, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("frz6", 1, 4'h0,0, 4'h7,1, 4'h0,0);
        next_cycle();
        @(negedge CLK); chk_all("frz7", 1, 4'h0,0, 4'h0,0, 4'h7,1);
        next_cycle();
        @(negedge CLK); chk_all("frz8", 0, 4'h0,0, 4'h0,0, 4'h0,0);
        check_stats("after freeze", 16'd9);
        next_cycle();
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) next_cycle();

        // flush during STALL with p1=7 ends the stall at once.
        drive(1, 4'h7, 1, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("fl0", 0, 4'h0,0, 4'h0,0, 4'h0,0);
        next_cycle();
        drive(1, 4'h7, 1, 1, 0, 0, 0, 0);
        @(negedge CLK); chk_all("fl1", 1, 4'h7,1, 4'h0,0, 4'h0,0);
        next_cycle();
        drive(1, 4'h7, 1, 0, 0, 0, 0, 1);
        @(negedge CLK); chk_all("fl2", 1, 4'h0,0, 4'h7,1, 4'h0,0);
        next_cycle();
        drive(1, 4'h5, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("fl3", 0, 4'h0,0, 4'h0,0, 4'h7,1);
        next_cycle();
        drive(1, 4'h6, 1, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("fl4", 0, 4'h5,0, 4'h0,0, 4'h0,0);
        next_cycle();
        // flush while frozen: p1 cleared, p2/p3 hold.
        drive(1, 4'h9, 1, 0, 0, 0, 1, 1);
        @(negedge CLK); chk_all("fl5", 0, 4'h6,1, 4'h5,0, 4'h0,0);
        next_cycle();
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("fl6", 0, 4'h0,0, 4'h5,0, 4'h0,0);
        check_stats("after flush", 16'd11);
        for (int k = 0; k < 3; k++) next_cycle();

        // Reset in the middle of a stall.
        drive(1, 4'h9, 1, 1, 0, 0, 0, 0);
        @(negedge CLK); chk_all("rst0", 1, 4'h0,0, 4'h0,0, 4'h0,0);
        next_cycle();
        drive(1, 4'h9, 1, 0, 0, 0, 0, 0);
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        @(negedge CLK); chk_all("rst1", 0, 4'h0,0, 4'h0,0, 4'h0,0);
        check_stats("after mid-stall reset", 16'd0);
        next_cycle();
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK); chk_all("rst2", 0, 4'h9,1, 4'h0,0, 4'h0,0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
